mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Byte-wide RAM access sequencer. It accepts one CPU request per
//   transaction and performs either one 8-bit access or a 16-bit
//   little-endian access split into two byte accesses at consecutive
//   addresses. The address wraps at 16 bits. Each byte waits WAIT_STATES
//   cycles and then commits on the first cycle in which mem_ready is high.
//   Completion is reported with a one-cycle cpu_ack pulse.
//
// Parameters
//   WAIT_STATES     extra cycles per byte before commit (0..15)
//   TIMEOUT_CYCLES  stall limit in consecutive not-ready cycles (1..255);
//                   used only when MEM_ACCESS_TIMEOUT_EN is defined
//
// Optional feature macro
//   MEM_ACCESS_TIMEOUT_EN  when this macro is defined, the block aborts a
//                          stalled byte after TIMEOUT_CYCLES and reports
//                          cpu_err. When it is not defined, cpu_err is 0
//                          and stalls wait forever.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cpu_req    access request, sampled only in IDLE
//   cpu_we     1 = write, 0 = read
//   cpu_word   1 = 16-bit little-endian access, 0 = byte access
//   cpu_addr   start byte address
//   cpu_wdata  write data (low byte used for byte writes)
//   cpu_ack    one-cycle completion pulse
//   cpu_err    timeout flag, valid with cpu_ack
//   cpu_rdata  read result, held until the next read commit
//   busy       high whenever not IDLE
//   mem_addr   RAM byte address
//   mem_wdata  RAM write data
//   mem_we     RAM write enable
//   mem_re     RAM read enable
//   mem_rdata  RAM combinational read data
//   mem_ready  RAM ready
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_word,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  if (WAIT_STATES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("mem_access_ctrl: WAIT_STATES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nx;

  // Latched request fields and per-byte progress
  logic [15:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic        we_q, we_nx;
  logic        word_q, word_nx;
  logic        idx_q, idx_nx;
  logic [3:0]  wcnt_q, wcnt_nx;

  // Next values of the registered outputs
  logic [15:0] rdata_nx;
  logic [15:0] mem_addr_nx;
  logic [7:0]  mem_wdata_nx;
  logic        mem_re_nx;
  logic        we_arm, we_arm_nx;
  logic        busy_nx;
  logic        ack_nx;

  logic at_zero;
  logic commit;
  logic stall;
  logic last_byte;
  logic timeout;

  // mem_we must rise and fall within the single commit cycle, and it must
  // stay low while the RAM stalls. The write strobe is therefore armed from
  // a register and qualified by mem_ready, so mem_we lines up with the
  // registered mem_addr and mem_wdata for the byte that commits.
  assign mem_we = we_arm & mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin : next_state
    at_zero   = (wcnt_q == '0);
    commit    = (state == ACCESS) && at_zero && mem_ready;
    stall     = (state == ACCESS) && at_zero && !mem_ready;
    last_byte = !word_q || idx_q;
    state_nx  = state;
    case (state)
      IDLE:    if (cpu_req) state_nx = ACCESS;
      ACCESS:  if ((commit && last_byte) || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin : output_next
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    we_nx    = we_q;
    word_nx  = word_q;
    idx_nx   = idx_q;
    wcnt_nx  = wcnt_q;
    rdata_nx = cpu_rdata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          addr_nx  = cpu_addr;
          wdata_nx = cpu_wdata;
          we_nx    = cpu_we;
          word_nx  = cpu_word;
          idx_nx   = 1'b0;
          wcnt_nx  = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!at_zero) begin
          wcnt_nx = wcnt_q - 4'd1;
        end else if (commit) begin
          if (!we_q) begin
            if (!idx_q) begin
              // A byte read clears the high half. A word read keeps the
              // high half until its second byte lands.
              rdata_nx = {(word_q ? cpu_rdata[15:8] : 8'h00), mem_rdata};
            end else begin
              rdata_nx[15:8] = mem_rdata;
            end
          end
          if (!last_byte) begin
            idx_nx  = 1'b1;
            wcnt_nx = 4'(WAIT_STATES);
          end
        end
      end
      default: ;
    endcase

    // Outputs are computed for the coming cycle, so they are already valid
    // in the first ACCESS cycle.
    busy_nx      = (state_nx != IDLE);
    ack_nx       = (state_nx == DONE);
    mem_addr_nx  = '0;
    mem_wdata_nx = '0;
    mem_re_nx    = 1'b0;
    we_arm_nx    = 1'b0;
    if (state_nx == ACCESS) begin
      mem_addr_nx = addr_nx + 16'(idx_nx);
      mem_re_nx   = !we_nx;
      we_arm_nx   = we_nx && (wcnt_nx == '0);
      if (we_nx) begin
        mem_wdata_nx = idx_nx ? wdata_nx[15:8] : wdata_nx[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : data_regs
    if (!reset_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      word_q    <= 1'b0;
      idx_q     <= 1'b0;
      wcnt_q    <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      we_arm    <= 1'b0;
    end else begin
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      we_q      <= we_nx;
      word_q    <= word_nx;
      idx_q     <= idx_nx;
      wcnt_q    <= wcnt_nx;
      cpu_rdata <= rdata_nx;
      cpu_ack   <= ack_nx;
      busy      <= busy_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_re    <= mem_re_nx;
      we_arm    <= we_arm_nx;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] stall_q;

  // The abort fires on the stall cycle that makes the run TIMEOUT_CYCLES long.
  assign timeout = stall && (stall_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin : stall_regs
    if (!reset_n) begin
      stall_q <= '0;
      cpu_err <= 1'b0;
    end else begin
      stall_q <= stall ? stall_q + 8'd1 : '0;
      cpu_err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int unsigned WS = 1;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_word;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [15:0] cpu_rdata;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  // ram: the RAM as the DUT sees it. model_ram: the contents the bench expects.
  logic [7:0]  ram       [0:65535];
  logic [7:0]  model_ram [0:65535];
  logic [15:0] last_rd;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  assign mem_rdata = ram[mem_addr];

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .WAIT_STATES   (WS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_word (cpu_word),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_err  (cpu_err),
    .cpu_rdata(cpu_rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_cpu_inputs();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_word  = 1'($urandom_range(0, 1));
    cpu_addr  = 16'($urandom);
    cpu_wdata = 16'($urandom);
  endtask

  // Called at negedge+1 of an IDLE cycle. It returns at negedge+1 of the
  // next IDLE cycle.
  // mode 0: mem_ready always high. mode 1: random stalls (runs of at most
  // 3). mode 2: exactly 3 stall cycles at the first commit point.
  task automatic run_txn(input logic we, input logic word, input logic [15:0] addr,
                         input logic [15:0] wdata, input int mode);
    bit          rdy[64];
    int          run;
    int          t, c0, c1, t_ack, cyc, ack_cyc, nexp, nwr;
    bit          got;
    logic [15:0] a1, exp_rd, exp_ma;
    logic [7:0]  exp_wd;
    logic [15:0] ea[2];
    logic [7:0]  ed[2];
    int          ec[2];
    logic [15:0] wa[4];
    logic [7:0]  wd[4];
    int          wc[4];
    int          busy_bad, addr_bad, re_bad, wd_bad;
    logic        err_at_ack;
    logic [15:0] rd_at_ack;

    run = 0;
    for (int i = 0; i < 64; i++) begin
      if (mode == 0) rdy[i] = 1'b1;
      else if (mode == 2) rdy[i] = !(i >= int'(1 + WS) && i < int'(4 + WS));
      else if (run < 3 && $urandom_range(0, 2) == 0) begin rdy[i] = 1'b0; run++; end
      else begin rdy[i] = 1'b1; run = 0; end
    end

    // Schedule from the rules: wait WS cycles, then commit on the first
    // ready cycle. For a word, the second byte repeats this after the
    // first commit. The ack comes one cycle after the last commit.
    t = 1 + int'(WS);
    while (!rdy[t]) t++;
    c0 = t;
    c1 = c0;
    if (word) begin
      t = c0 + 1 + int'(WS);
      while (!rdy[t]) t++;
      c1 = t;
    end
    t_ack = c1 + 1;

    a1 = addr + 16'd1;
    nexp = 0;
    if (we) begin
      ea[0] = addr; ed[0] = wdata[7:0]; ec[0] = c0; nexp = 1;
      model_ram[addr] = wdata[7:0];
      if (word) begin
        ea[1] = a1; ed[1] = wdata[15:8]; ec[1] = c1; nexp = 2;
        model_ram[a1] = wdata[15:8];
      end
      exp_rd = last_rd;
    end else begin
      exp_rd = word ? {model_ram[a1], model_ram[addr]} : {8'h00, model_ram[addr]};
      last_rd = exp_rd;
    end

    for (int k = 0; k < 4; k++) begin wa[k] = '0; wd[k] = '0; wc[k] = 0; end
    nwr = 0; busy_bad = 0; addr_bad = 0; re_bad = 0; wd_bad = 0;
    got = 1'b0; ack_cyc = -1; err_at_ack = 1'b0; rd_at_ack = '0;

    cpu_req = 1'b1; cpu_we = we; cpu_word = word; cpu_addr = addr; cpu_wdata = wdata;
    mem_ready = rdy[0];
    @(negedge clk);
    cyc = 1;
    while (!got && cyc < 40) begin
      scramble_cpu_inputs();
      mem_ready = rdy[cyc];
      #1;
      if (mem_we) begin
        if (nwr < 4) begin wa[nwr] = mem_addr; wd[nwr] = mem_wdata; wc[nwr] = cyc; end
        nwr++;
        ram[mem_addr] = mem_wdata;
      end
      if (!busy) busy_bad++;
      if (cpu_ack) begin
        got = 1'b1; ack_cyc = cyc; err_at_ack = cpu_err; rd_at_ack = cpu_rdata;
      end else begin
        exp_ma = (word && cyc > c0) ? a1 : addr;
        exp_wd = !we ? 8'h00 : ((word && cyc > c0) ? wdata[15:8] : wdata[7:0]);
        if (mem_addr !== exp_ma) addr_bad++;
        if (mem_re !== !we) re_bad++;
        if (mem_wdata !== exp_wd) wd_bad++;
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    cpu_req = 1'b0;

    check_val("ack_latency", ack_cyc, t_ack);
    check_val("cpu_err_at_ack", err_at_ack, 0);
    check_val("cpu_rdata_at_ack", rd_at_ack, exp_rd);
    check_val("busy_low_cycles", busy_bad, 0);
    check_val("mem_addr_bad_cycles", addr_bad, 0);
    check_val("mem_re_bad_cycles", re_bad, 0);
    check_val("mem_wdata_bad_cycles", wd_bad, 0);
    check_val("mem_we_count", nwr, nexp);
    for (int k = 0; k < nexp; k++) begin
      check_val("write_addr", wa[k], ea[k]);
      check_val("write_data", wd[k], ed[k]);
      check_val("write_cycle", wc[k], ec[k]);
    end

    // The ack lasts one cycle, and the block is back in IDLE on the next cycle.
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_val("idle_after_done", {cpu_ack, cpu_err, busy, mem_re, mem_we}, 0);
  endtask

  initial begin : stimulus
    logic [7:0] v;
    int         cnt, cyc;
    bit         seen, got;

    cpu_req = 1'b0; cpu_we = 1'b0; cpu_word = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_ready = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ram[i] = v;
      model_ram[i] = v;
    end

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_val("reset_outputs",
              {cpu_ack, cpu_err, cpu_rdata, busy, mem_addr, mem_wdata, mem_we, mem_re}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Word write that wraps at the top of the address space
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 0);
    check_val("wrap_ram_ffff", ram[16'hFFFF], 8'hEF);
    check_val("wrap_ram_0000", ram[16'h0000], 8'hBE);

    // Word read assembled little-endian
    ram[16'h0010] = 8'h34; ram[16'h0011] = 8'h12;
    model_ram[16'h0010] = 8'h34; model_ram[16'h0011] = 8'h12;
    run_txn(1'b0, 1'b1, 16'h0010, 16'h0000, 0);
    check_val("word_read_value", cpu_rdata, 16'h1234);

    // Byte write followed by a byte read of the same location
    run_txn(1'b1, 1'b0, 16'h1234, 16'hFFA5, 0);
    run_txn(1'b0, 1'b0, 16'h1234, 16'h0000, 0);
    check_val("byte_read_value", cpu_rdata, 16'h00A5);

    // Three stall cycles at the commit point
    run_txn(1'b1, 1'b0, 16'h4000, 16'h0066, 2);
    run_txn(1'b0, 1'b1, 16'h4000, 16'h0000, 2);

    // Reset while the second byte of a word write is pending
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b1;
    cpu_addr = 16'h2000; cpu_wdata = 16'h5A3C; mem_ready = 1'b1;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cyc++;
      #1;
      if (mem_we) begin
        seen = 1'b1;
        ram[mem_addr] = mem_wdata;
      end
    end
    check_val("rst_first_byte_written", seen, 1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("rst_outputs_immediate",
              {cpu_ack, cpu_err, cpu_rdata, busy, mem_addr, mem_wdata, mem_we, mem_re}, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      #1;
      if (mem_we) begin cnt++; ram[mem_addr] = mem_wdata; end
    end
    check_val("rst_no_second_write", cnt, 0);
    check_val("rst_idle_after_release", {busy, cpu_ack}, 0);
    check_val("rst_byte0_ram", ram[16'h2000], 8'h3C);
    check_val("rst_byte1_ram", ram[16'h2001], model_ram[16'h2001]);
    model_ram[16'h2000] = 8'h3C;
    last_rd = '0;

`ifdef MEM_ACCESS_TIMEOUT_EN
    // mem_ready held low: the access aborts after TO stall cycles
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b0;
    cpu_addr = 16'h3000; cpu_wdata = 16'h0077; mem_ready = 1'b0;
    cnt = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cyc++;
      #1;
      if (mem_we) cnt++;
      if (cpu_ack) begin
        got = 1'b1;
        check_val("timeout_latency", cyc, 1 + WS + TO);
        check_val("timeout_err", cpu_err, 1);
        check_val("timeout_rdata_kept", cpu_rdata, last_rd);
      end
    end
    check_val("timeout_ack_seen", got, 1);
    check_val("timeout_no_write", cnt, 0);
    check_val("timeout_ram_kept", ram[16'h3000], model_ram[16'h3000]);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_val("timeout_idle", {cpu_ack, cpu_err, busy}, 0);
`endif

    // Random traffic near the wrap point, with random stalls
    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'hFFF0 + 16'($urandom_range(0, 31)), 16'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
